mem_port_arbiter: RTL and testbench

//  Shares one memory port between instruction fetch (IF) and load/store (LS) requesters.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arb_prio.sv | 56 +++++
 rtl/mem_port_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory port arbiter.
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } arb_owner_t;

  // Instruction fetches are always full-word accesses.
  localparam logic [2:0] IF_ACCESS_CTRL = 3'b010;

endpackage

// File: rtl/mem_arb_prio.sv
// Priority select between fetch and load/store with a starvation guard for fetch.
// Load/store normally wins. After STARVE_LIMIT consecutive load/store wins over a
// waiting fetch, the fetch is forced through on the next contended grant.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arb_en_i,
  input  logic       if_req_i,
  input  logic       ls_req_i,
  output logic       win_valid_o,
  output arb_owner_t win_owner_o
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_q;
  logic [CNT_W-1:0] starve_cnt_d;
  logic             if_forced;

  // Pick the winner of this cycle's arbitration.
  always_comb begin
    if_forced   = (starve_cnt_q >= LIMIT);
    win_valid_o = arb_en_i && (if_req_i || ls_req_i);
    win_owner_o = OWN_LS;
    if (if_req_i && (!ls_req_i || if_forced)) begin
      win_owner_o = OWN_IF;
    end
  end

  // Track how many times a waiting fetch has been passed over.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (win_valid_o) begin
      if (win_owner_o == OWN_IF) begin
        starve_cnt_d = '0;
      end else if (if_req_i && (starve_cnt_q < LIMIT)) begin
        starve_cnt_d = starve_cnt_q + 1'b1;
      end
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// One transaction is in flight at a time; it is held on the port for MEM_LATENCY
// cycles and its read data / ack is returned to the owner on the following cycle.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  input  logic                  ls_req_i,
  input  logic                  ls_we_i,
  input  logic [ADDR_WIDTH-1:0] ls_addr_i,
  input  logic [DATA_WIDTH-1:0] ls_wdata_i,
  input  logic [2:0]            ls_ctrl_i,
  output logic                  ls_gnt_o,
  output logic                  ls_rvalid_o,
  output logic [DATA_WIDTH-1:0] ls_rdata_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [2:0]            mem_ctrl_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam int LAT_W = $clog2(MEM_LATENCY + 1);
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LATENCY - 1);

  arb_state_t            state_q, state_d;
  logic [LAT_W-1:0]      lat_cnt_q, lat_cnt_d;
  arb_owner_t            owner_q, owner_d;
  logic                  we_q, we_d;
  logic                  first_q, first_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [2:0]            ctrl_q, ctrl_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] ls_rdata_q, ls_rdata_d;
  logic                  if_rvalid_q, if_rvalid_d;
  logic                  ls_rvalid_q, ls_rvalid_d;

  logic                  arb_en;
  logic                  win_valid;
  arb_owner_t            win_owner;

  // Grants are only possible while idle, and never while reset is held.
  assign arb_en = (state_q == IDLE) && !rst;

  mem_arb_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .clk        (clk),
    .rst        (rst),
    .arb_en_i   (arb_en),
    .if_req_i   (if_req_i),
    .ls_req_i   (ls_req_i),
    .win_valid_o(win_valid),
    .win_owner_o(win_owner)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: leave IDLE on a grant, return after the last busy cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_valid) state_d = BUSY;
      BUSY:    if (lat_cnt_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: combinational grants and the memory strobes.
  always_comb begin
    if_gnt_o  = win_valid && (win_owner == OWN_IF);
    ls_gnt_o  = win_valid && (win_owner == OWN_LS);
    mem_req_o = (state_q == BUSY);
    mem_we_o  = (state_q == BUSY) && we_q && first_q;
  end

  // Transaction latch on grant, latency countdown, and response capture on the last beat.
  always_comb begin
    lat_cnt_d   = lat_cnt_q;
    owner_d     = owner_q;
    we_d        = we_q;
    first_d     = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    ctrl_d      = ctrl_q;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    if_rvalid_d = 1'b0;
    ls_rvalid_d = 1'b0;
    if (win_valid) begin
      owner_d   = win_owner;
      lat_cnt_d = LAT_INIT;
      first_d   = 1'b1;
      if (win_owner == OWN_LS) begin
        addr_d  = ls_addr_i;
        wdata_d = ls_wdata_i;
        ctrl_d  = ls_ctrl_i;
        we_d    = ls_we_i;
      end else begin
        addr_d  = if_addr_i;
        wdata_d = '0;
        ctrl_d  = IF_ACCESS_CTRL;
        we_d    = 1'b0;
      end
    end else if (state_q == BUSY) begin
      if (lat_cnt_q != '0) begin
        lat_cnt_d = lat_cnt_q - 1'b1;
      end else if (owner_q == OWN_IF) begin
        if_rdata_d  = mem_rdata_i;
        if_rvalid_d = 1'b1;
      end else begin
        ls_rdata_d  = we_q ? '0 : mem_rdata_i;
        ls_rvalid_d = 1'b1;
      end
    end
  end

  // Datapath and response registers; reset drops any in-flight transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_cnt_q   <= '0;
      owner_q     <= OWN_IF;
      we_q        <= 1'b0;
      first_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ctrl_q      <= '0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
    end else begin
      lat_cnt_q   <= lat_cnt_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      first_q     <= first_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ctrl_q      <= ctrl_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
      if_rvalid_q <= if_rvalid_d;
      ls_rvalid_q <= ls_rvalid_d;
    end
  end

  assign if_rvalid_o = if_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign ls_rvalid_o = ls_rvalid_q;
  assign ls_rdata_o  = ls_rdata_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_ctrl_o  = ctrl_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Two instances share the stimulus bus:
// dut_a runs with MEM_LATENCY=1 and dut_b with MEM_LATENCY=3; 'sel' routes the
// requests to one of them and picks which instance's outputs are observed.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;

  logic        if_req;
  logic [31:0] if_addr;
  logic        ls_req;
  logic        ls_we;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [2:0]  ls_ctrl;

  logic        a_if_gnt, a_if_rvalid, a_ls_gnt, a_ls_rvalid, a_mem_req, a_mem_we;
  logic [31:0] a_if_rdata, a_ls_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic [2:0]  a_mem_ctrl;
  logic        b_if_gnt, b_if_rvalid, b_ls_gnt, b_ls_rvalid, b_mem_req, b_mem_we;
  logic [31:0] b_if_rdata, b_ls_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [2:0]  b_mem_ctrl;

  logic        o_if_gnt, o_if_rvalid, o_ls_gnt, o_ls_rvalid, o_mem_req, o_mem_we;
  logic [31:0] o_if_rdata, o_ls_rdata, o_mem_addr, o_mem_wdata;
  logic [2:0]  o_mem_ctrl;

  typedef struct {
    logic        is_ls;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  // Memory contents are a fixed scramble of the address, so every word is distinct.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  assign a_mem_rdata = memf(a_mem_addr);
  assign b_mem_rdata = memf(b_mem_addr);

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1), .STARVE_LIMIT(4)
  ) dut_a (
    .clk(clk), .rst(rst),
    .if_req_i(if_req & ~sel), .if_addr_i(if_addr),
    .if_gnt_o(a_if_gnt), .if_rvalid_o(a_if_rvalid), .if_rdata_o(a_if_rdata),
    .ls_req_i(ls_req & ~sel), .ls_we_i(ls_we), .ls_addr_i(ls_addr),
    .ls_wdata_i(ls_wdata), .ls_ctrl_i(ls_ctrl),
    .ls_gnt_o(a_ls_gnt), .ls_rvalid_o(a_ls_rvalid), .ls_rdata_o(a_ls_rdata),
    .mem_req_o(a_mem_req), .mem_we_o(a_mem_we), .mem_addr_o(a_mem_addr),
    .mem_wdata_o(a_mem_wdata), .mem_ctrl_o(a_mem_ctrl), .mem_rdata_i(a_mem_rdata)
  );

  mem_port_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(3), .STARVE_LIMIT(4)
  ) dut_b (
    .clk(clk), .rst(rst),
    .if_req_i(if_req & sel), .if_addr_i(if_addr),
    .if_gnt_o(b_if_gnt), .if_rvalid_o(b_if_rvalid), .if_rdata_o(b_if_rdata),
    .ls_req_i(ls_req & sel), .ls_we_i(ls_we), .ls_addr_i(ls_addr),
    .ls_wdata_i(ls_wdata), .ls_ctrl_i(ls_ctrl),
    .ls_gnt_o(b_ls_gnt), .ls_rvalid_o(b_ls_rvalid), .ls_rdata_o(b_ls_rdata),
    .mem_req_o(b_mem_req), .mem_we_o(b_mem_we), .mem_addr_o(b_mem_addr),
    .mem_wdata_o(b_mem_wdata), .mem_ctrl_o(b_mem_ctrl), .mem_rdata_i(b_mem_rdata)
  );

  // Route the observed instance's outputs onto one set of names.
  always_comb begin
    o_if_gnt    = sel ? b_if_gnt    : a_if_gnt;
    o_if_rvalid = sel ? b_if_rvalid : a_if_rvalid;
    o_if_rdata  = sel ? b_if_rdata  : a_if_rdata;
    o_ls_gnt    = sel ? b_ls_gnt    : a_ls_gnt;
    o_ls_rvalid = sel ? b_ls_rvalid : a_ls_rvalid;
    o_ls_rdata  = sel ? b_ls_rdata  : a_ls_rdata;
    o_mem_req   = sel ? b_mem_req   : a_mem_req;
    o_mem_we    = sel ? b_mem_we    : a_mem_we;
    o_mem_addr  = sel ? b_mem_addr  : a_mem_addr;
    o_mem_wdata = sel ? b_mem_wdata : a_mem_wdata;
    o_mem_ctrl  = sel ? b_mem_ctrl  : a_mem_ctrl;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic ir, input logic [31:0] ia, input logic lr,
                               input logic lwe, input logic [31:0] la,
                               input logic [31:0] lwd, input logic [2:0] lc);
    if_req   = ir;
    if_addr  = ia;
    ls_req   = lr;
    ls_we    = lwe;
    ls_addr  = la;
    ls_wdata = lwd;
    ls_ctrl  = lc;
  endtask

  task automatic idleStimulus();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
  endtask

  task automatic expectResp(input logic is_ls, input logic [31:0] data);
    exp_t e;
    e.is_ls = is_ls;
    e.data  = data;
    sb_q.push_back(e);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Every response pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (o_if_rvalid || o_ls_rvalid) begin
      checkBit("sb_single_rvalid", o_if_rvalid & o_ls_rvalid, 1'b0);
      checkBit("sb_rvalid_expected", sb_q.size() != 0, 1'b1);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        checkBit("sb_owner_is_ls", o_ls_rvalid, mon_e.is_ls);
        checkOutput("sb_rdata", o_ls_rvalid ? o_ls_rdata : o_if_rdata, mon_e.data);
      end
    end
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  ls_n;
    int  if_n;
    logic exp_if;
    logic [31:0] cur_if_addr;
    logic [31:0] cur_ls_addr;

    // Reset with requests pending: nothing may be granted while reset is held.
    applyStimulus(1'b1, 32'h4, 1'b1, 1'b0, 32'h8, 32'h0, 3'b000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkBit("rst_if_gnt", o_if_gnt, 1'b0);
    checkBit("rst_ls_gnt", o_ls_gnt, 1'b0);
    checkBit("rst_mem_req", o_mem_req, 1'b0);
    checkOutput("rst_mem_addr", o_mem_addr, 32'h0);
    checkBit("rst_if_rvalid", o_if_rvalid, 1'b0);
    nextCycle();
    idleStimulus();
    rst = 1'b0;

    // Fetch only, latency 1: grant, one busy cycle, then rvalid.
    nextCycle();
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    @(negedge clk);
    checkBit("t1_if_gnt", o_if_gnt, 1'b1);
    checkBit("t1_ls_gnt", o_ls_gnt, 1'b0);
    checkBit("t1_mem_req_c0", o_mem_req, 1'b0);
    expectResp(1'b0, memf(32'h0));
    nextCycle();
    idleStimulus();
    @(negedge clk);
    checkBit("t1_mem_req_c1", o_mem_req, 1'b1);
    checkOutput("t1_mem_addr", o_mem_addr, 32'h0);
    checkOutput("t1_mem_ctrl", {29'd0, o_mem_ctrl}, 32'd2);
    checkBit("t1_mem_we", o_mem_we, 1'b0);
    checkBit("t1_if_rvalid_c1", o_if_rvalid, 1'b0);
    nextCycle();
    @(negedge clk);
    checkBit("t1_if_rvalid_c2", o_if_rvalid, 1'b1);
    checkOutput("t1_if_rdata", o_if_rdata, memf(32'h0));
    checkBit("t1_mem_req_c2", o_mem_req, 1'b0);
    nextCycle();
    @(negedge clk);
    checkBit("t1_if_rvalid_c3", o_if_rvalid, 1'b0);
    checkOutput("t1_if_rdata_hold", o_if_rdata, memf(32'h0));

    // Both request with no starvation history: load first, fetch on the load's rvalid cycle.
    nextCycle();
    applyStimulus(1'b1, 32'h40, 1'b1, 1'b0, 32'h100, 32'h0, 3'b100);
    @(negedge clk);
    checkBit("t2_ls_gnt", o_ls_gnt, 1'b1);
    checkBit("t2_if_gnt", o_if_gnt, 1'b0);
    expectResp(1'b1, memf(32'h100));
    nextCycle();
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    @(negedge clk);
    checkBit("t2_if_gnt_busy", o_if_gnt, 1'b0);
    checkOutput("t2_mem_addr_ls", o_mem_addr, 32'h100);
    checkOutput("t2_mem_ctrl_ls", {29'd0, o_mem_ctrl}, 32'd4);
    nextCycle();
    @(negedge clk);
    checkBit("t2_ls_rvalid", o_ls_rvalid, 1'b1);
    checkBit("t2_if_gnt_on_rvalid", o_if_gnt, 1'b1);
    expectResp(1'b0, memf(32'h40));
    nextCycle();
    idleStimulus();
    @(negedge clk);
    checkOutput("t2_mem_addr_if", o_mem_addr, 32'h40);
    checkOutput("t2_mem_ctrl_if", {29'd0, o_mem_ctrl}, 32'd2);
    nextCycle();
    @(negedge clk);
    checkBit("t2_if_rvalid", o_if_rvalid, 1'b1);

    // Continuous contention: four loads/stores win, then the starved fetch is forced through.
    ls_n = 0;
    if_n = 0;
    for (int k = 0; k < 10; k++) begin
      nextCycle();
      cur_if_addr = 32'(32'h800 + if_n * 4);
      cur_ls_addr = 32'(32'h200 + ls_n * 4);
      applyStimulus(1'b1, cur_if_addr, 1'b1, 1'b0, cur_ls_addr, 32'h0, 3'b010);
      @(negedge clk);
      exp_if = ((k % 5) == 4);
      checkBit($sformatf("t3_if_gnt_%0d", k), o_if_gnt, exp_if);
      checkBit($sformatf("t3_ls_gnt_%0d", k), o_ls_gnt, !exp_if);
      if (exp_if) begin
        expectResp(1'b0, memf(cur_if_addr));
        if_n++;
      end else begin
        expectResp(1'b1, memf(cur_ls_addr));
        ls_n++;
      end
      nextCycle();
      @(negedge clk);
      checkBit($sformatf("t3_no_gnt_busy_%0d", k), o_if_gnt | o_ls_gnt, 1'b0);
    end
    nextCycle();
    idleStimulus();
    @(negedge clk);
    checkBit("t3_no_gnt_after", o_if_gnt | o_ls_gnt, 1'b0);

    // Latency 3: a load, then a back-to-back store granted on the load's rvalid cycle.
    nextCycle();
    sel = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h30, 32'h0, 3'b010);
    @(negedge clk);
    checkBit("t4_ld_gnt", o_ls_gnt, 1'b1);
    expectResp(1'b1, memf(32'h30));
    nextCycle();
    idleStimulus();
    @(negedge clk);
    checkBit("t4_ld_mem_req_c1", o_mem_req, 1'b1);
    checkBit("t4_ld_mem_we_c1", o_mem_we, 1'b0);
    nextCycle();
    nextCycle();
    @(negedge clk);
    checkBit("t4_ld_mem_req_c3", o_mem_req, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF, 3'b010);
    @(negedge clk);
    checkBit("t4_ld_rvalid", o_ls_rvalid, 1'b1);
    checkOutput("t4_ld_rdata", o_ls_rdata, memf(32'h30));
    checkBit("t4_st_gnt", o_ls_gnt, 1'b1);
    expectResp(1'b1, 32'h0);
    nextCycle();
    idleStimulus();
    @(negedge clk);
    checkBit("t4_st_mem_we_c1", o_mem_we, 1'b1);
    checkBit("t4_st_mem_req_c1", o_mem_req, 1'b1);
    checkOutput("t4_st_mem_addr", o_mem_addr, 32'h20);
    checkOutput("t4_st_mem_wdata", o_mem_wdata, 32'hDEAD_BEEF);
    nextCycle();
    @(negedge clk);
    checkBit("t4_st_mem_we_c2", o_mem_we, 1'b0);
    checkBit("t4_st_mem_req_c2", o_mem_req, 1'b1);
    nextCycle();
    @(negedge clk);
    checkBit("t4_st_mem_we_c3", o_mem_we, 1'b0);
    checkBit("t4_st_mem_req_c3", o_mem_req, 1'b1);
    nextCycle();
    @(negedge clk);
    checkBit("t4_st_rvalid", o_ls_rvalid, 1'b1);
    checkOutput("t4_st_rdata", o_ls_rdata, 32'h0);
    checkBit("t4_st_mem_req_done", o_mem_req, 1'b0);

    // Reset in the second of three busy cycles discards the fetch entirely.
    nextCycle();
    applyStimulus(1'b1, 32'h60, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    @(negedge clk);
    checkBit("t5_if_gnt", o_if_gnt, 1'b1);
    nextCycle();
    idleStimulus();
    nextCycle();
    rst = 1'b1;
    #2;
    checkBit("t5_rst_mem_req", o_mem_req, 1'b0);
    checkOutput("t5_rst_mem_addr", o_mem_addr, 32'h0);
    checkOutput("t5_rst_mem_ctrl", {29'd0, o_mem_ctrl}, 32'd0);
    checkBit("t5_rst_if_rvalid", o_if_rvalid, 1'b0);
    nextCycle();
    rst = 1'b0;
    repeat (4) nextCycle();
    @(negedge clk);
    checkBit("t5_no_rvalid", o_if_rvalid | o_ls_rvalid, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h70, 32'h0, 3'b000);
    @(negedge clk);
    checkBit("t5_next_gnt", o_ls_gnt, 1'b1);
    expectResp(1'b1, memf(32'h70));
    nextCycle();
    idleStimulus();
    repeat (3) nextCycle();
    @(negedge clk);
    checkBit("t5_next_rvalid", o_ls_rvalid, 1'b1);

    // A load/store request that disappears before the clock edge starts nothing.
    nextCycle();
    @(negedge clk);
    #1;
    ls_req  = 1'b1;
    ls_addr = 32'h90;
    #2;
    ls_req  = 1'b0;
    nextCycle();
    @(negedge clk);
    checkBit("t6_no_ls_gnt", o_ls_gnt, 1'b0);
    checkBit("t6_no_mem_req", o_mem_req, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 32'hA0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    @(negedge clk);
    checkBit("t6_if_gnt_idle", o_if_gnt, 1'b1);
    expectResp(1'b0, memf(32'hA0));
    nextCycle();
    idleStimulus();
    repeat (3) nextCycle();
    @(negedge clk);
    checkBit("t6_if_rvalid", o_if_rvalid, 1'b1);

    nextCycle();
    @(negedge clk);
    checkOutput("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
